// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front-end.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr}; flush beats push/pop.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pushes to a full FIFO and pops from an empty one are silently ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches over req/ack, buffers results,
// and restarts on branch/jump redirects.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  output logic         IMemReq,
  output logic [31:0]  IMemAddr,
  input  logic         IMemAck,
  input  logic [31:0]  IMemRData,
  output logic [31:0]  Instr,
  output logic [31:0]  InstrPC,
  output logic         InstrValid,
  input  logic         InstrReady,
  input  logic         Redirect,
  input  logic [31:0]  RedirectPC,
  output fetch_state_t DbgState
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: memory side holds IMemReq/IMemAddr stable until IMemAck; core
  // side transfers the head entry in any cycle with InstrValid & InstrReady.
  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   redirect_pc;
  logic          push, pop, pop_req, flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_after;
  fetch_entry_t  wentry, head;

  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;
  assign pop_req     = ~fifo_empty & InstrReady;
  assign count_after = fifo_count + CW'(1) - CW'(pop_req);
  assign wentry      = '{pc: fetch_pc_q, instr: IMemRData};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    pop        = pop_req;
    flush      = 1'b0;
    if (Redirect) begin
      flush = 1'b1;
      pop   = 1'b0;
      // An in-flight request cannot be abandoned, so its response is parked in DROP.
      if (state_q == IDLE || IMemAck) begin
        state_d    = REQ;
        fetch_pc_d = redirect_pc;
      end else begin
        state_d   = DROP;
        pend_pc_d = redirect_pc;
      end
    end else begin
      case (state_q)
        IDLE: if (!fifo_full) state_d = REQ;
        REQ: if (IMemAck) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after < CW'(DEPTH)) ? REQ : IDLE;
        end
        DROP: if (IMemAck) begin
          state_d    = REQ;
          fetch_pc_d = pend_pc_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign IMemReq    = (state_q != IDLE);
  assign IMemAddr   = fetch_pc_q;
  assign InstrValid = ~fifo_empty;
  assign Instr      = fifo_empty ? 32'h0 : head.instr;
  assign InstrPC    = fifo_empty ? 32'h0 : head.pc;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, and a
// randomized run against a queue-based scoreboard of the expected instruction stream.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic         Clk, Reset_n;
  logic         IMemReq, IMemAck, InstrValid, InstrReady, Redirect;
  logic [31:0]  IMemAddr, IMemRData, Instr, InstrPC, RedirectPC;
  fetch_state_t dbg_state;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemRData  (IMemRData),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .DbgState   (dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        req_e;
    logic [31:0] addr_e;
    logic        valid_e;
    logic [31:0] instr_e;
    logic [31:0] pc_e;
  } vec_t;
  vec_t vecs[11];

  // Scoreboard: PCs fetched and kept, in delivery order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch, hold_addr;
  logic        outstanding, tainted, hold_pending;
  int          n_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, ".req"},   IMemReq,    req);
    chk({tag, ".addr"},  IMemAddr,   addr);
    chk({tag, ".valid"}, InstrValid, valid);
    chk({tag, ".instr"}, Instr,      instr);
    chk({tag, ".pc"},    InstrPC,    pc);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] rpc);
    IMemAck    = ack;
    IMemRData  = rdata;
    InstrReady = ready;
    Redirect   = redir;
    RedirectPC = rpc;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench sampling cycle 1 after reset release.
  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_out(tag, 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic        ack, ready, redir;
    logic [31:0] rpc, rdata;

    vecs[0]  = '{1'b1, 32'h2008_0005, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 32'h1111_0004, 1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 32'h2008_0005, 32'hBFC0_0000};
    vecs[2]  = '{1'b1, 32'h1111_0008, 1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0004, 32'hBFC0_0004};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC0_000C, 1'b1, 32'h1111_0008, 32'hBFC0_0008};
    vecs[9]  = '{1'b1, 32'h1111_000C, 1'b1, 1'b1, 32'hBFC0_000C, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'h1111_000C, 32'hBFC0_000C};

    // Zero-wait start-up, then 5 cycles of backpressure and resume.
    do_reset("rst0");
    for (int i = 0; i < 11; i++) begin
      chk_out($sformatf("vec%0d", i), vecs[i].req_e, vecs[i].addr_e, vecs[i].valid_e,
              vecs[i].instr_e, vecs[i].pc_e);
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].ready, 1'b0, 32'h0);
      tick();
    end

    // Redirect in the first wait cycle of a 3-cycle-late ack.
    do_reset("rst1");
    chk_out("late.c1", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0010); tick();
    chk_out("late.c2", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    chk_out("late.c3", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    chk_out("late.c4", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0); tick();
    chk_out("late.c5", 1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0); tick();
    chk_out("late.c6", 1'b1, 32'h0040_0014, 1'b1, 32'h1234_5678, 32'h0040_0010);

    // Redirect with ack and pop while two entries are buffered; unaligned target.
    drive(1'b1, 32'h2222_0014, 1'b0, 1'b0, 32'h0); tick();
    chk_out("flush.c7", 1'b0, 32'h0040_0018, 1'b1, 32'h1234_5678, 32'h0040_0010);
    drive(1'b1, 32'hDEAD_0001, 1'b1, 1'b1, 32'h0040_0023); tick();
    chk_out("flush.c8", 1'b1, 32'h0040_0020, 1'b0, 32'h0, 32'h0);
    // Redirect coinciding with an ack in REQ: data dropped, refetch next cycle.
    drive(1'b1, 32'hDEAD_0002, 1'b1, 1'b1, 32'hFFFF_FFF8); tick();
    chk_out("wrap.c9", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hA1A1_A1A1, 1'b0, 1'b0, 32'h0); tick();
    chk_out("wrap.c10", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hA1A1_A1A1, 32'hFFFF_FFF8);
    drive(1'b1, 32'hA2A2_A2A2, 1'b0, 1'b0, 32'h0); tick();
    chk_out("wrap.c11", 1'b0, 32'h0000_0000, 1'b1, 32'hA1A1_A1A1, 32'hFFFF_FFF8);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    chk_out("wrap.c12", 1'b0, 32'h0000_0000, 1'b1, 32'hA2A2_A2A2, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    chk_out("wrap.c13", 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset while a request waits; a late ack must be ignored.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2 Reset_n = 1'b0;
    #1 chk_out("arst.now", 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("arst.held", 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    #2 Reset_n = 1'b1;
    tick();
    chk_out("arst.r1", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h2008_0005, 1'b1, 1'b0, 32'h0); tick();
    chk_out("arst.r2", 1'b1, RPC + 32'd4, 1'b1, 32'h2008_0005, RPC);

    // Randomized run against the stream scoreboard.
    do_reset("rst2");
    exp_q.delete();
    exp_fetch    = RPC;
    outstanding  = 1'b0;
    tainted      = 1'b0;
    hold_pending = 1'b0;
    hold_addr    = 32'h0;
    n_deliv      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.align", {30'h0, IMemAddr[1:0]}, 32'h0);
      if (hold_pending) begin
        chk("rnd.hold_req", IMemReq, 1'b1);
        chk("rnd.hold_addr", IMemAddr, hold_addr);
      end
      chk("rnd.depth", exp_q.size() <= DEPTH, 1'b1);
      chk("rnd.valid", InstrValid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rnd.pc", InstrPC, exp_q[0]);
        chk("rnd.instr", Instr, mem_word(exp_q[0]));
      end else begin
        chk("rnd.idle_instr", Instr, 32'h0);
      end

      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom();
      if (IMemReq) ack = (((cyc / 200) % 2) == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      else         ack = ($urandom_range(0, 7) == 0);
      rdata = (ack && IMemReq) ? mem_word(IMemAddr) : $urandom();

      if (InstrValid && ready && !redir && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_deliv++;
      end
      if (IMemReq && !outstanding) begin
        outstanding = 1'b1;
        tainted     = 1'b0;
      end
      if (redir && outstanding) tainted = 1'b1;
      if (ack && outstanding) begin
        if (!tainted) begin
          chk("rnd.fetch_pc", IMemAddr, exp_fetch);
          exp_q.push_back(IMemAddr);
          exp_fetch = exp_fetch + 32'd4;
        end
        outstanding = 1'b0;
      end
      if (redir) begin
        exp_q.delete();
        exp_fetch = rpc & 32'hFFFF_FFFC;
      end
      hold_pending = IMemReq && !ack;
      hold_addr    = IMemAddr;

      drive(ack, rdata, ready, redir, rpc);
      tick();
    end
    chk("rnd.deliveries", n_deliv >= 300, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
